// File: rtl/dcache_wb_issue.sv
// Data-cache write-back issue unit: hands dirty victim lines to the write buffer and
// issues single-beat uncached stores on AXI-lite after the buffer has drained.
module dcache_wb_issue (
  input  logic         clk,
  input  logic         rst,
  // victim line from the cache
  input  logic         evict_valid,
  output logic         evict_ready,
  input  logic [31:0]  evict_paddr,
  input  logic [255:0] evict_data,
  output logic         evict_done,
  // uncached store from the cache
  input  logic         uc_valid,
  output logic         uc_ready,
  input  logic [31:0]  uc_addr,
  input  logic [31:0]  uc_wdata,
  input  logic [3:0]   uc_wstrb,
  output logic         uc_done,
  output logic         busy,
  // write-buffer line interface
  output logic         wreq,
  input  logic         wreq_recvd,
  input  logic         wdone,
  output logic [31:0]  wdata_paddr,
  output logic [31:0]  wdata_bank0,
  output logic [31:0]  wdata_bank1,
  output logic [31:0]  wdata_bank2,
  output logic [31:0]  wdata_bank3,
  output logic [31:0]  wdata_bank4,
  output logic [31:0]  wdata_bank5,
  output logic [31:0]  wdata_bank6,
  output logic [31:0]  wdata_bank7,
  // write-buffer control
  input  logic         empty,
  output logic         clear_req,
  input  logic         clear_done,
  output logic         uchd_wreq,
  // uncached AXI-lite write channel
  output logic [31:0]  dch_awaddr,
  output logic [3:0]   dch_awlen,
  output logic [1:0]   dch_awburst,
  output logic         dch_awvalid,
  input  logic         dch_awready,
  output logic [31:0]  dch_wdata,
  output logic [3:0]   dch_wstrb,
  output logic         dch_wlast,
  output logic         dch_wvalid,
  input  logic         dch_wready,
  input  logic         dch_bvalid
);

  typedef enum logic [2:0] {
    IDLE, WREQ, WAIT_DONE, UC_CLEAR, UC_AW, UC_W, UC_B
  } state_t;

  state_t         state;
  logic [31:0]    ev_paddr_q;
  logic [255:0]   ev_data_q;
  logic [31:0]    uc_addr_q;
  logic [31:0]    uc_wdata_q;
  logic [3:0]     uc_wstrb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ev_paddr_q <= '0;
      ev_data_q  <= '0;
      uc_addr_q  <= '0;
      uc_wdata_q <= '0;
      uc_wstrb_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (evict_valid) begin
            ev_paddr_q <= evict_paddr;
            ev_data_q  <= evict_data;
            state      <= WREQ;
          end else if (uc_valid) begin
            uc_addr_q  <= uc_addr;
            uc_wdata_q <= uc_wdata;
            uc_wstrb_q <= uc_wstrb;
            // drain buffered lines first so the uncached store cannot overtake them
            state      <= empty ? UC_AW : UC_CLEAR;
          end
        end
        WREQ:      if (wreq_recvd)  state <= WAIT_DONE;
        WAIT_DONE: if (wdone)       state <= IDLE;
        UC_CLEAR:  if (clear_done)  state <= UC_AW;
        UC_AW:     if (dch_awready) state <= UC_W;
        UC_W:      if (dch_wready)  state <= UC_B;
        UC_B:      if (dch_bvalid)  state <= IDLE;
        default:                    state <= IDLE;
      endcase
    end
  end

  assign evict_ready = (state == IDLE);
  assign uc_ready    = (state == IDLE) && !evict_valid;
  assign busy        = (state != IDLE);

  // completion pulses follow the handshake in the same cycle; reset suppresses them
  assign evict_done  = (state == WAIT_DONE) && wdone && !rst;
  assign uc_done     = (state == UC_B) && dch_bvalid && !rst;

  assign wreq        = (state == WREQ);
  assign clear_req   = (state == UC_CLEAR);
  assign uchd_wreq   = (state == UC_AW) || (state == UC_W) || (state == UC_B);

  assign wdata_paddr = ev_paddr_q;
  assign wdata_bank0 = ev_data_q[31:0];
  assign wdata_bank1 = ev_data_q[63:32];
  assign wdata_bank2 = ev_data_q[95:64];
  assign wdata_bank3 = ev_data_q[127:96];
  assign wdata_bank4 = ev_data_q[159:128];
  assign wdata_bank5 = ev_data_q[191:160];
  assign wdata_bank6 = ev_data_q[223:192];
  assign wdata_bank7 = ev_data_q[255:224];

  assign dch_awaddr  = uc_addr_q;
  assign dch_awlen   = 4'd0;
  assign dch_awburst = 2'b01;
  assign dch_awvalid = (state == UC_AW);
  assign dch_wdata   = uc_wdata_q;
  assign dch_wstrb   = uc_wstrb_q;
  assign dch_wvalid  = (state == UC_W);
  assign dch_wlast   = (state == UC_W);

endmodule

// File: tb/tb_dcache_wb_issue.sv
// Transaction-level bench for dcache_wb_issue: each eviction / uncached store is played
// with chosen handshake delays and every cycle is checked against the expected phase.
module tb_dcache_wb_issue;

  logic         clk = 1'b0;
  logic         rst;
  logic         evict_valid, evict_ready, evict_done;
  logic [31:0]  evict_paddr;
  logic [255:0] evict_data;
  logic         uc_valid, uc_ready, uc_done, busy;
  logic [31:0]  uc_addr, uc_wdata;
  logic [3:0]   uc_wstrb;
  logic         wreq, wreq_recvd, wdone;
  logic [31:0]  wdata_paddr;
  logic [31:0]  wdata_bank0, wdata_bank1, wdata_bank2, wdata_bank3;
  logic [31:0]  wdata_bank4, wdata_bank5, wdata_bank6, wdata_bank7;
  logic         empty, clear_req, clear_done, uchd_wreq;
  logic [31:0]  dch_awaddr, dch_wdata;
  logic [3:0]   dch_awlen, dch_wstrb;
  logic [1:0]   dch_awburst;
  logic         dch_awvalid, dch_awready, dch_wlast, dch_wvalid, dch_wready, dch_bvalid;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  dcache_wb_issue dut (
    .clk(clk), .rst(rst),
    .evict_valid(evict_valid), .evict_ready(evict_ready), .evict_paddr(evict_paddr),
    .evict_data(evict_data), .evict_done(evict_done),
    .uc_valid(uc_valid), .uc_ready(uc_ready), .uc_addr(uc_addr), .uc_wdata(uc_wdata),
    .uc_wstrb(uc_wstrb), .uc_done(uc_done), .busy(busy),
    .wreq(wreq), .wreq_recvd(wreq_recvd), .wdone(wdone), .wdata_paddr(wdata_paddr),
    .wdata_bank0(wdata_bank0), .wdata_bank1(wdata_bank1), .wdata_bank2(wdata_bank2),
    .wdata_bank3(wdata_bank3), .wdata_bank4(wdata_bank4), .wdata_bank5(wdata_bank5),
    .wdata_bank6(wdata_bank6), .wdata_bank7(wdata_bank7),
    .empty(empty), .clear_req(clear_req), .clear_done(clear_done), .uchd_wreq(uchd_wreq),
    .dch_awaddr(dch_awaddr), .dch_awlen(dch_awlen), .dch_awburst(dch_awburst),
    .dch_awvalid(dch_awvalid), .dch_awready(dch_awready), .dch_wdata(dch_wdata),
    .dch_wstrb(dch_wstrb), .dch_wlast(dch_wlast), .dch_wvalid(dch_wvalid),
    .dch_wready(dch_wready), .dch_bvalid(dch_bvalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] banks();
    return {wdata_bank7, wdata_bank6, wdata_bank5, wdata_bank4,
            wdata_bank3, wdata_bank2, wdata_bank1, wdata_bank0};
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"},        256'(busy),        256'(0));
    chk({tag, ".wreq"},        256'(wreq),        256'(0));
    chk({tag, ".clear_req"},   256'(clear_req),   256'(0));
    chk({tag, ".uchd_wreq"},   256'(uchd_wreq),   256'(0));
    chk({tag, ".awvalid"},     256'(dch_awvalid), 256'(0));
    chk({tag, ".wvalid"},      256'(dch_wvalid),  256'(0));
    chk({tag, ".wlast"},       256'(dch_wlast),   256'(0));
    chk({tag, ".evict_done"},  256'(evict_done),  256'(0));
    chk({tag, ".uc_done"},     256'(uc_done),     256'(0));
    chk({tag, ".evict_ready"}, 256'(evict_ready), 256'(1));
    chk({tag, ".uc_ready"},    256'(uc_ready),    256'(!evict_valid));
  endtask

  // Victim line: wreq must last d_recvd+1 cycles, then evict_done pulses on the
  // (d_done+1)-th cycle of waiting, with wdone noise during the request phase ignored.
  task automatic do_evict(input logic [31:0] pa, input logic [255:0] d,
                          input int unsigned d_recvd, input int unsigned d_done);
    evict_valid = 1'b1; evict_paddr = pa; evict_data = d;
    #1;
    chk("ev.accept_ready", 256'(evict_ready), 256'(1));
    chk("ev.accept_ucrdy", 256'(uc_ready), 256'(0));
    cyc();
    evict_valid = 1'b0; evict_paddr = $urandom; evict_data = rnd256();
    for (int unsigned i = 0; i <= d_recvd; i++) begin
      wreq_recvd = (i == d_recvd);
      wdone = 1'($urandom_range(0, 1));
      #1;
      chk("ev.wreq",     256'(wreq), 256'(1));
      chk("ev.paddr",    256'(wdata_paddr), 256'(pa));
      chk("ev.banks",    banks(), d);
      chk("ev.done_early", 256'(evict_done), 256'(0));
      chk("ev.ready_busy", 256'({busy, evict_ready, uc_ready}), 256'(3'b100));
      cyc();
    end
    wreq_recvd = 1'b0;
    for (int unsigned i = 0; i <= d_done; i++) begin
      wdone = (i == d_done);
      #1;
      chk("ev.wreq_off",  256'(wreq), 256'(0));
      chk("ev.done",      256'(evict_done), 256'(i == d_done));
      chk("ev.ready_busy2", 256'({busy, evict_ready}), 256'(2'b10));
      cyc();
    end
    wdone = 1'b0;
    #1;
    chk_idle("ev.after");
  endtask

  // Uncached store: n_clear is the total clear_req length when the buffer is not empty.
  task automatic do_uc(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                       input logic emp, input int unsigned n_clear, input int unsigned d_aw,
                       input int unsigned d_w, input int unsigned d_b);
    uc_valid = 1'b1; uc_addr = a; uc_wdata = wd; uc_wstrb = st; empty = emp;
    #1;
    chk("uc.accept_ready", 256'(uc_ready), 256'(1));
    cyc();
    uc_valid = 1'b0; uc_addr = $urandom; uc_wdata = $urandom; uc_wstrb = 4'($urandom);
    empty = 1'($urandom_range(0, 1));
    if (!emp) begin
      for (int unsigned i = 0; i < n_clear; i++) begin
        clear_done = (i == n_clear - 1);
        #1;
        chk("uc.clear_req", 256'(clear_req), 256'(1));
        chk("uc.clr_quiet", 256'({dch_awvalid, uchd_wreq, busy, uc_ready}), 256'(4'b0010));
        cyc();
      end
      clear_done = 1'b0;
    end
    for (int unsigned i = 0; i <= d_aw; i++) begin
      dch_awready = (i == d_aw);
      dch_bvalid = 1'($urandom_range(0, 1));
      dch_wready = 1'($urandom_range(0, 1));
      #1;
      chk("uc.aw_valid", 256'({clear_req, dch_awvalid, uchd_wreq, dch_wvalid}), 256'(4'b0110));
      chk("uc.aw_addr",  256'(dch_awaddr), 256'(a));
      chk("uc.aw_lenbur", 256'({dch_awlen, dch_awburst}), 256'(6'b000001));
      chk("uc.aw_nodone", 256'(uc_done), 256'(0));
      cyc();
    end
    dch_awready = 1'b0;
    for (int unsigned i = 0; i <= d_w; i++) begin
      dch_wready = (i == d_w);
      dch_bvalid = 1'($urandom_range(0, 1));
      dch_awready = 1'($urandom_range(0, 1));
      #1;
      chk("uc.w_valid", 256'({dch_awvalid, dch_wvalid, dch_wlast, uchd_wreq}), 256'(4'b0111));
      chk("uc.w_data",  256'({dch_wstrb, dch_wdata}), 256'({st, wd}));
      chk("uc.w_nodone", 256'(uc_done), 256'(0));
      cyc();
    end
    dch_wready = 1'b0; dch_awready = 1'b0;
    for (int unsigned i = 0; i <= d_b; i++) begin
      dch_bvalid = (i == d_b);
      #1;
      chk("uc.b_state", 256'({dch_wvalid, uchd_wreq, evict_ready}), 256'(3'b010));
      chk("uc.done",    256'(uc_done), 256'(i == d_b));
      cyc();
    end
    dch_bvalid = 1'b0;
    #1;
    chk_idle("uc.after");
  endtask

  initial begin
    logic [255:0] d;
    rst = 1'b1;
    evict_valid = 0; evict_paddr = '0; evict_data = '0;
    uc_valid = 0; uc_addr = '0; uc_wdata = '0; uc_wstrb = '0;
    wreq_recvd = 0; wdone = 0; empty = 1; clear_done = 0;
    dch_awready = 0; dch_wready = 0; dch_bvalid = 0;
    repeat (2) cyc();
    rst = 1'b0;
    #1;
    chk_idle("reset");
    chk("reset.awlen", 256'({dch_awlen, dch_awburst}), 256'(6'b000001));
    cyc();

    // spurious completions in IDLE
    for (int i = 0; i < 5; i++) begin
      wdone = 1'b1; dch_bvalid = 1'b1; clear_done = 1'($urandom_range(0, 1));
      wreq_recvd = 1'($urandom_range(0, 1)); dch_awready = 1'($urandom_range(0, 1));
      #1;
      chk_idle("spurious");
      cyc();
    end
    wdone = 0; dch_bvalid = 0; clear_done = 0; wreq_recvd = 0; dch_awready = 0;
    #1;
    chk_idle("spurious.after");
    cyc();

    for (int k = 0; k < 8; k++) d[32*k +: 32] = 32'hA0 + 32'(k);
    do_evict(32'h1FC0_0020, d, 3, 2);
    do_uc(32'hBFAF_F000, 32'h1234_5678, 4'b0011, 1'b1, 0, 2, 1, 3);
    do_uc(32'h8000_0040, 32'hDEAD_BEEF, 4'b1111, 1'b0, 20, 0, 0, 0);

    // simultaneous requests: eviction wins, uc waits for one IDLE cycle after evict_done
    uc_valid = 1'b1; uc_addr = 32'hA000_1004; uc_wdata = 32'hCAFE_F00D; uc_wstrb = 4'b1100;
    do_evict(32'h0000_1000, rnd256(), 0, 0);
    do_uc(32'hA000_1004, 32'hCAFE_F00D, 4'b1100, 1'b1, 0, 1, 0, 1);

    // reset while in UC_W
    uc_valid = 1'b1; uc_addr = 32'h1111_2220; empty = 1'b1;
    cyc();
    uc_valid = 1'b0; dch_awready = 1'b1;
    cyc();
    dch_awready = 1'b0;
    #1;
    chk("rst_w.in_w", 256'(dch_wvalid), 256'(1));
    rst = 1'b1; dch_bvalid = 1'b1; dch_wready = 1'b1;
    #1;
    chk("rst_w.uc_done", 256'(uc_done), 256'(0));
    cyc();
    rst = 1'b0; dch_bvalid = 1'b0; dch_wready = 1'b0;
    #1;
    chk_idle("rst_w");
    cyc();

    // reset while in WAIT_DONE, with wdone arriving in the reset cycle
    evict_valid = 1'b1; evict_paddr = 32'h2222_3340; evict_data = rnd256();
    cyc();
    evict_valid = 1'b0; wreq_recvd = 1'b1;
    cyc();
    wreq_recvd = 1'b0;
    #1;
    chk("rst_wd.in_wait", 256'({wreq, busy}), 256'(2'b01));
    rst = 1'b1; wdone = 1'b1;
    #1;
    chk("rst_wd.evict_done", 256'(evict_done), 256'(0));
    cyc();
    rst = 1'b0; wdone = 1'b0;
    #1;
    chk_idle("rst_wd");
    cyc();

    // randomized mix
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 1) == 1)
        do_evict($urandom, rnd256(), $urandom_range(0, 4), $urandom_range(0, 4));
      else
        do_uc($urandom, $urandom, 4'($urandom), 1'($urandom_range(0, 1)),
              $urandom_range(1, 5), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_wb_issue.md
DCACHE_WB_ISSUE -- requirements
Module: dcache_wb_issue

Interface
REQ-001 SHALL have ports: clk input 1, clock, rising edge; rst input 1, reset, synchronous, active-high.
REQ-002 SHALL have cache-side victim ports: evict_valid in 1; evict_ready out 1; evict_paddr in 32; evict_data in 256, word k at [32k+31:32k]; evict_done out 1.
REQ-003 SHALL have cache-side uncached ports: uc_valid in 1; uc_ready out 1; uc_addr in 32; uc_wdata in 32; uc_wstrb in 4; uc_done out 1; busy out 1.
REQ-004 SHALL have write-buffer line ports: wreq out 1; wreq_recvd in 1; wdone in 1; wdata_paddr out 32; wdata_bank0..wdata_bank7 out 32 each.
REQ-005 SHALL have write-buffer control ports: empty in 1; clear_req out 1; clear_done in 1; uchd_wreq out 1.
REQ-006 SHALL have uncached AXI-lite ports: dch_awaddr out 32; dch_awlen out 4; dch_awburst out 2; dch_awvalid out 1; dch_awready in 1; dch_wdata out 32; dch_wstrb out 4; dch_wlast out 1; dch_wvalid out 1; dch_wready in 1; dch_bvalid in 1.

Function
REQ-007 SHALL implement FSM states IDLE, WREQ, WAIT_DONE, UC_CLEAR, UC_AW, UC_W, UC_B.
REQ-008 SHALL drive evict_ready=1 only in IDLE; uc_ready=1 only in IDLE with evict_valid=0, so eviction wins simultaneous requests.
REQ-009 SHALL, on evict_valid&evict_ready, latch evict_paddr and evict_data into registers and enter WREQ next cycle.
REQ-010 SHALL hold wreq=1 with wdata_paddr/banks from the latch throughout WREQ, including the cycle wreq_recvd=1; wreq_recvd -> WAIT_DONE.
REQ-011 SHALL ignore wdone outside WAIT_DONE; in WAIT_DONE, wdone=1 -> IDLE and evict_done=1 in that same cycle (combinational, exactly one cycle).
REQ-012 SHALL, on uc_valid&uc_ready, latch uc_addr, uc_wdata, uc_wstrb; go to UC_AW if empty=1 that cycle, else UC_CLEAR.
REQ-013 SHALL hold clear_req=1 throughout UC_CLEAR; clear_done=1 -> UC_AW (uncached store never overtakes buffered lines).
REQ-014 SHALL drive uchd_wreq=1 in UC_AW, UC_W, UC_B; 0 in all other states.
REQ-015 SHALL in UC_AW drive dch_awvalid=1, dch_awaddr=latched addr, dch_awlen=0, dch_awburst=2'b01; dch_awready=1 -> UC_W.
REQ-016 SHALL in UC_W drive dch_wvalid=1, dch_wlast=1, dch_wdata/dch_wstrb from latch; dch_wready=1 -> UC_B.
REQ-017 SHALL in UC_B wait for dch_bvalid=1 -> IDLE, with uc_done=1 in that cycle only.
REQ-018 SHALL drive dch_awvalid, dch_wvalid, dch_wlast, wreq, clear_req to 0 outside their states; dch_awlen=0 and dch_awburst=2'b01 constant.
REQ-019 SHALL drive busy=1 in every state except IDLE.
REQ-020 SHALL keep latched data stable from acceptance until return to IDLE; new evict_data/uc inputs ignored while busy.
REQ-021 SHALL not accept a new request in the cycle it returns to IDLE from another state (ready first asserts the following cycle).

Reset
REQ-022 SHALL on rst=1 enter IDLE next edge, regardless of current state, discarding any in-flight request without completion pulse.
REQ-023 SHALL hold after reset: wreq=0, clear_req=0, uchd_wreq=0, dch_awvalid=0, dch_wvalid=0, dch_wlast=0, evict_done=0, uc_done=0, busy=0, evict_ready=1, uc_ready=1 when evict_valid=0; latch registers = 0.

Verification
REQ-024 SHALL cover: evict paddr=0x1FC0_0020, word k=0xA0+k; wreq_recvd delayed 3 cycles, wdone 2 cycles later -> wreq high exactly 4 cycles, banks 0xA0..0xA7, evict_done one pulse, busy low next cycle.
REQ-025 SHALL cover: uc write addr=0xBFAF_F000 data=0x1234_5678 strb=4'b0011 with empty=1 -> no clear_req; awvalid until awready; wvalid/wlast until wready; uc_done on bvalid; uchd_wreq high in all 3 AXI states.
REQ-026 SHALL cover: uc write with empty=0, clear_done after 20 cycles -> clear_req high 20 cycles, dch_awvalid=0 until UC_AW.
REQ-027 SHALL cover: evict_valid and uc_valid same cycle -> eviction accepted, uc_ready=0; uc accepted only after evict_done and one IDLE cycle.
REQ-028 SHALL cover: rst asserted in UC_W and again in WAIT_DONE -> next cycle IDLE, all strobes 0, no uc_done/evict_done.
REQ-029 SHALL cover: spurious wdone/dch_bvalid in IDLE -> no state change, no done pulses.
